// File: rtl/td4x_pkg.sv
// td4x_pkg: shared definitions for the td4x CPU core.
//   OPC_W       opcode width of the fixed ISA
//   OP_*        opcode encodings
//   state_t     control FSM encoding (ST_LOAD, ST_RUN, ST_HALT)
package td4x_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_ADD_A  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_MOV_AB = 4'b0001;  // A = B
  localparam logic [OPC_W-1:0] OP_IN_A   = 4'b0010;
  localparam logic [OPC_W-1:0] OP_MOV_A  = 4'b0011;  // A = imm
  localparam logic [OPC_W-1:0] OP_MOV_BA = 4'b0100;  // B = A
  localparam logic [OPC_W-1:0] OP_ADD_B  = 4'b0101;
  localparam logic [OPC_W-1:0] OP_IN_B   = 4'b0110;
  localparam logic [OPC_W-1:0] OP_MOV_B  = 4'b0111;  // B = imm
  localparam logic [OPC_W-1:0] OP_HALT   = 4'b1000;  // NOP unless TD4X_HALT_EN
  localparam logic [OPC_W-1:0] OP_OUT_B  = 4'b1001;
  localparam logic [OPC_W-1:0] OP_OUT_I  = 4'b1011;
  localparam logic [OPC_W-1:0] OP_JNC    = 4'b1110;
  localparam logic [OPC_W-1:0] OP_JMP    = 4'b1111;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

endpackage

// File: rtl/td4x_prog_mem.sv
// td4x_prog_mem: 2**W x DW program store. Synchronous write, asynchronous
// read, no reset (contents survive core reset).
//   clk    system clock
//   we     write strobe
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data (combinational)
module td4x_prog_mem #(
  parameter int W  = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [W-1:0]  waddr,
  input  logic [DW-1:0] wdata,
  input  logic [W-1:0]  raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/td4x_core.sv
// td4x_core: parametrised TD4-style CPU with writable program store and a
// LOAD/RUN control FSM. One instruction executes per cycle with tick=1 in RUN.
//   clk        system clock
//   rst        synchronous active-high reset (program store kept)
//   tick       execute one instruction this cycle (RUN only)
//   run        1: LOAD->RUN / stay in RUN, 0: RUN->LOAD
//   prog_we    program write strobe (LOAD only)
//   prog_addr  program write address
//   prog_data  instruction {opcode, imm}
//   sw_in      input port
//   led        registered output port
//   pc         program counter
//   carry      carry flag
//   running    FSM is in RUN
//   halted     FSM is in HALT (only with TD4X_HALT_EN)
// Build option: define TD4X_HALT_EN to make opcode 1000 a sticky HALT.
module td4x_core #(
  parameter int W     = 4,
  parameter int OPC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               run,
  input  logic               prog_we,
  input  logic [W-1:0]       prog_addr,
  input  logic [OPC_W+W-1:0] prog_data,
  input  logic [W-1:0]       sw_in,
  output logic [W-1:0]       led,
  output logic [W-1:0]       pc,
  output logic               carry,
`ifdef TD4X_HALT_EN
  output logic               halted,
`endif
  output logic               running
);

  import td4x_pkg::*;

  state_t             st_q, st_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d, pc_q, pc_d, led_q, led_d;
  logic               c_q, c_d;
  logic [OPC_W+W-1:0] instr;
  logic [OPC_W-1:0]   opc;
  logic [W-1:0]       imm;
  logic [W:0]         sum_a, sum_b;
  logic               exec, mem_we, halt_hit;

  assign exec   = (st_q == ST_RUN) && tick;
  assign mem_we = (st_q == ST_LOAD) && prog_we;

  td4x_prog_mem #(.W(W), .DW(OPC_W+W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_q),
    .rdata (instr)
  );

  assign opc   = instr[OPC_W+W-1 -: OPC_W];
  assign imm   = instr[W-1:0];
  assign sum_a = {1'b0, a_q} + {1'b0, imm};
  assign sum_b = {1'b0, b_q} + {1'b0, imm};

  // Datapath: every executed instruction clears carry unless it is an ADD.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    pc_d     = pc_q;
    led_d    = led_q;
    halt_hit = 1'b0;
    if (exec) begin
      c_d  = 1'b0;
      pc_d = pc_q + W'(1);
      case (opc)
        OP_ADD_A:  begin a_d = sum_a[W-1:0]; c_d = sum_a[W]; end
        OP_ADD_B:  begin b_d = sum_b[W-1:0]; c_d = sum_b[W]; end
        OP_MOV_A:  a_d = imm;
        OP_MOV_B:  b_d = imm;
        OP_MOV_AB: a_d = b_q;
        OP_MOV_BA: b_d = a_q;
        OP_IN_A:   a_d = sw_in;
        OP_IN_B:   b_d = sw_in;
        OP_OUT_B:  led_d = b_q;
        OP_OUT_I:  led_d = imm;
        OP_JMP:    pc_d = imm;
        OP_JNC:    if (!c_q) pc_d = imm;  // carry from the previous instruction
`ifdef TD4X_HALT_EN
        OP_HALT:   begin pc_d = pc_q; halt_hit = 1'b1; end
`endif
        default: ;
      endcase
    end
  end

  // Control FSM. A tick in the same cycle as run=0 still executes.
  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_LOAD: if (run) st_d = ST_RUN;
      ST_RUN: begin
        if (halt_hit)  st_d = ST_HALT;
        else if (!run) st_d = ST_LOAD;
      end
      ST_HALT: st_d = ST_HALT;
      default: st_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= ST_LOAD;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= 1'b0;
      pc_q  <= '0;
      led_q <= '0;
    end else begin
      st_q  <= st_d;
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      pc_q  <= pc_d;
      led_q <= led_d;
    end
  end

  assign led     = led_q;
  assign pc      = pc_q;
  assign carry   = c_q;
  assign running = (st_q == ST_RUN);
`ifdef TD4X_HALT_EN
  assign halted  = (st_q == ST_HALT);
`endif

endmodule

// File: tb/tb_td4x_core.sv
// Bench for td4x_core: W=4 instance checked against a behavioural ISA model
// (randomized and directed), plus a W=8 instance for wide carry/JNC cases.
module tb_td4x_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1, tick = 1'b0, run = 1'b0, prog_we = 1'b0;
  logic [3:0] prog_addr = '0, sw = '0;
  logic [7:0] prog_data = '0;
  logic [3:0] led, pc;
  logic       carry, running;

  logic        rst8 = 1'b1, tick8 = 1'b0, run8 = 1'b0, we8 = 1'b0;
  logic [7:0]  addr8 = '0, sw8 = '0, led8, pc8;
  logic [11:0] data8 = '0;
  logic        carry8, running8;
`ifdef TD4X_HALT_EN
  logic halted, halted8;
`endif

  int checks = 0, passes = 0;

  always #5 clk = ~clk;

  td4x_core #(.W(4)) u4 (
    .clk(clk), .rst(rst), .tick(tick), .run(run), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .sw_in(sw),
    .led(led), .pc(pc), .carry(carry),
`ifdef TD4X_HALT_EN
    .halted(halted),
`endif
    .running(running)
  );

  td4x_core #(.W(8)) u8 (
    .clk(clk), .rst(rst8), .tick(tick8), .run(run8), .prog_we(we8),
    .prog_addr(addr8), .prog_data(data8), .sw_in(sw8),
    .led(led8), .pc(pc8), .carry(carry8),
`ifdef TD4X_HALT_EN
    .halted(halted8),
`endif
    .running(running8)
  );

  // ---------------- reference model (W=4) ----------------
  int mm [16];
  int mA, mB, mc, mpc, mled, ms;  // ms: 0 load, 1 run, 2 halt

  function automatic logic [9:0] mexp();
    return {4'(mled), 4'(mpc), 1'(mc), ms == 1};
  endfunction

  task automatic model_edge();
    int op, im, s, npc, nc;
    bit hlt;
    if (rst) begin
      mA = 0; mB = 0; mc = 0; mpc = 0; mled = 0; ms = 0;
      return;
    end
    if (ms == 0) begin
      if (prog_we) mm[prog_addr] = int'(prog_data);
      if (run) ms = 1;
    end else if (ms == 1) begin
      hlt = 0;
      if (tick) begin
        op = mm[mpc] / 16; im = mm[mpc] % 16;
        npc = (mpc + 1) % 16; nc = 0;
        case (op)
          0:  begin s = mA + im; mA = s % 16; nc = s / 16; end
          5:  begin s = mB + im; mB = s % 16; nc = s / 16; end
          3:  mA = im;
          7:  mB = im;
          1:  mA = mB;
          4:  mB = mA;
          2:  mA = int'(sw);
          6:  mB = int'(sw);
          9:  mled = mB;
          11: mled = im;
          15: npc = im;
          14: npc = mc ? (mpc + 1) % 16 : im;
`ifdef TD4X_HALT_EN
          8:  begin npc = mpc; hlt = 1; end
`endif
          default: ;
        endcase
        mc = nc; mpc = npc;
      end
      if (hlt) ms = 2;
      else if (!run) ms = 0;
    end
  endtask

  task automatic step(input logic tk, input logic rn, input logic we,
                      input logic [3:0] ad, input logic [7:0] dt);
    tick = tk; run = rn; prog_we = we; prog_addr = ad; prog_data = dt;
    model_edge();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic load_count_prog();
    step(0, 0, 1, 4'd0, 8'hB7);  // OUT 7
    step(0, 0, 1, 4'd1, 8'h01);  // ADD A,1
    step(0, 0, 1, 4'd2, 8'hE1);  // JNC 1
    step(0, 0, 1, 4'd3, 8'hF3);  // JMP 3
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    checks++;
    if ({led, pc, carry, running} !== 10'd0)
      $display("FAIL reset: got %h want %h", {led, pc, carry, running}, 10'd0);
    else passes++;
    rst = 1'b0;
  endtask

  task automatic test_count();
    int k = 0;
    bit was_run;
    load_count_prog();
    for (int i = 0; i < 40; i++) begin
      was_run = (ms == 1);
      step(1, 1, 0, 0, 0);
      if (was_run) k++;
      checks++;
      if ({led, pc, carry, running} !== mexp())
        $display("FAIL count c%0d: got %h want %h", i, {led, pc, carry, running}, mexp());
      else passes++;
      if (was_run && k == 1) begin
        checks++;
        if (led !== 4'd7) $display("FAIL count_led7: got %h want 7", led);
        else passes++;
      end
      if (was_run && k >= 33) begin
        checks++;
        if (pc !== 4'd3) $display("FAIL count_pc3 t%0d: got %h want 3", k, pc);
        else passes++;
      end
    end
  endtask

  task automatic test_tick_hold();
    logic [9:0] snap;
    do_reset();
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(1, 1, 0, 0, 0);
    snap = {led, pc, carry, running};
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, 4'd1, 8'h03);  // write attempt in RUN must be ignored
      checks++;
      if ({led, pc, carry, running} !== snap)
        $display("FAIL hold c%0d: got %h want %h", i, {led, pc, carry, running}, snap);
      else passes++;
    end
    for (int i = 0; i < 30; i++) begin
      step(1'($urandom_range(0, 1)), 1, 0, 0, 0);
      checks++;
      if ({led, pc, carry, running} !== mexp())
        $display("FAIL hold_resume c%0d: got %h want %h", i, {led, pc, carry, running}, mexp());
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0);
    rst = 1'b1;
    step(1, 1, 0, 0, 0);
    rst = 1'b0;
    checks++;
    if ({led, pc, carry, running} !== 10'd0)
      $display("FAIL reset_mid: got %h want %h", {led, pc, carry, running}, 10'd0);
    else passes++;
    step(1, 1, 0, 0, 0);  // LOAD -> RUN, tick ignored
    step(1, 1, 0, 0, 0);
    checks++;
    if ({led, pc} !== {4'd7, 4'd1})
      $display("FAIL reset_mid_rom: got %h want %h", {led, pc}, {4'd7, 4'd1});
    else passes++;
  endtask

  task automatic test_in_out();
    do_reset();
    sw = 4'hA;
    step(0, 0, 1, 4'd0, 8'h20);  // IN A
    step(0, 0, 1, 4'd1, 8'h40);  // MOV B,A
    step(0, 0, 1, 4'd2, 8'h90);  // OUT B
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    checks++;
    if ({led, pc} !== {4'hA, 4'd3})
      $display("FAIL in_out: got %h want %h", {led, pc}, {4'hA, 4'd3});
    else passes++;
    step(0, 0, 0, 0, 0);
    checks++;
    if ({pc, running} !== {4'd3, 1'b0})
      $display("FAIL pause: got %h want %h", {pc, running}, {4'd3, 1'b0});
    else passes++;
    step(0, 1, 0, 0, 0);
    checks++;
    if ({led, pc, running} !== {4'hA, 4'd3, 1'b1})
      $display("FAIL resume: got %h want %h", {led, pc, running}, {4'hA, 4'd3, 1'b1});
    else passes++;
  endtask

  function automatic logic [7:0] rnd_instr();
    logic [7:0] d = 8'($urandom);
`ifdef TD4X_HALT_EN
    if (d[7:4] == 4'b1000) d[7:4] = 4'b0000;
`endif
    return d;
  endfunction

  task automatic test_random();
    do_reset();
    for (int a = 0; a < 16; a++) step(0, 0, 1, 4'(a), rnd_instr());
    for (int i = 0; i < 400; i++) begin
      sw = 4'($urandom);
      step(($urandom % 4) != 0, ($urandom % 10) != 0, 1'($urandom),
           4'($urandom), rnd_instr());
      checks++;
      if ({led, pc, carry, running} !== mexp())
        $display("FAIL random c%0d: got %h want %h", i, {led, pc, carry, running}, mexp());
      else passes++;
    end
  endtask

  task automatic test_w8();
    logic [11:0] prog [3];
    prog[0] = 12'h301;  // MOV A,0x01
    prog[1] = 12'h0FF;  // ADD A,0xFF
    prog[2] = 12'hE40;  // JNC 0x40
    rst8 = 1'b1; @(posedge clk); #1; rst8 = 1'b0;
    checks++;
    if ({pc8, carry8, running8} !== 10'd0)
      $display("FAIL w8_reset: got %h want 0", {pc8, carry8, running8});
    else passes++;
    for (int i = 0; i < 3; i++) begin
      we8 = 1'b1; addr8 = 8'(i); data8 = prog[i];
      @(posedge clk); #1;
    end
    we8 = 1'b0; run8 = 1'b1;
    @(posedge clk); #1;
    tick8 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({pc8, carry8} !== {8'd2, 1'b1})
      $display("FAIL w8_add: got %h want %h", {pc8, carry8}, {8'd2, 1'b1});
    else passes++;
    @(posedge clk); #1;
    tick8 = 1'b0;
    checks++;
    if ({pc8, carry8} !== {8'd3, 1'b0})
      $display("FAIL w8_jnc: got %h want %h", {pc8, carry8}, {8'd3, 1'b0});
    else passes++;
  endtask

`ifdef TD4X_HALT_EN
  task automatic test_halt();
    do_reset();
    step(0, 0, 1, 4'd0, 8'hB5);  // OUT 5
    step(0, 0, 1, 4'd1, 8'h80);  // HALT
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 1'($urandom), 1'($urandom), 4'd1, 8'hB9);
      checks++;
      if ({halted, led, pc, running} !== {1'b1, 4'd5, 4'd1, 1'b0})
        $display("FAIL halt c%0d: got %h want %h", i, {halted, led, pc, running},
                 {1'b1, 4'd5, 4'd1, 1'b0});
      else passes++;
    end
    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    rst = 1'b0;
    checks++;
    if ({halted, running, pc} !== 6'd0)
      $display("FAIL halt_reset: got %h want 0", {halted, running, pc});
    else passes++;
  endtask
`endif

  initial begin
    mA = 0; mB = 0; mc = 0; mpc = 0; mled = 0; ms = 0;
    for (int a = 0; a < 16; a++) mm[a] = 0;
    #1;
    test_reset();
    test_count();
    test_tick_hold();
    test_reset_mid();
    test_in_out();
    test_random();
    test_w8();
`ifdef TD4X_HALT_EN
    test_halt();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/td4x_core.md
Name: td4x_core

Overview:
Parametrised successor to the 4-bit TD4 CPU core.
- Data and address width set by parameter W.
- Program store is an internal writable ROM loaded through a write port, replacing 16 hard-wired memory input buses.
- Instruction execution is gated by a `tick` enable, so slow timer programs run from the system clock without a derived clock.
- A LOAD/RUN control FSM allows pausing, reloading and resuming the program.

Parameters:
W, 4, width of registers A/B, immediate, PC, sw_in and led; program depth is 2**W.
OPC_W, 4, opcode width (fixed ISA, not to be overridden); instruction width is OPC_W+W.

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
tick  in  1  execute one instruction this cycle (RUN state only)
run  in  1  1 = LOAD->RUN / stay in RUN; 0 = RUN->LOAD (pause)
prog_we  in  1  program write strobe (LOAD state only)
prog_addr  in  W  program write address
prog_data  in  OPC_W+W  instruction {opcode, imm}
sw_in  in  W  input port
led  out  W  output port (registered)
pc  out  W  program counter
carry  out  1  carry flag
running  out  1  1 while FSM is in RUN

Behaviour:
Reset (RST=1 at CLK edge):
- A=B=0, carry=0, pc=0, led=0, state=LOAD, running=0.
- Program store is NOT cleared; its contents survive reset.

FSM:
- LOAD: prog_we=1 writes prog_data to mem[prog_addr] at the clock edge. tick is ignored. run=1 -> RUN next cycle.
- RUN: prog_we is ignored. run=0 -> LOAD next cycle; pc/A/B/carry/led are retained, so the program resumes on return to RUN.
- If run=0 and tick=1 in the same RUN cycle, the tick executes, then the FSM enters LOAD.
- prog_we and run both 1 in LOAD: the write completes and the FSM enters RUN; the first executable tick is the following cycle.

Execution (RUN & tick):
- One instruction per tick; instr = mem[pc] (asynchronous read).
- All register, carry, led and pc updates are visible the cycle after the tick.

ISA (opcode : action; imm = instr[W-1:0]):
- 0000 ADD A,imm : {c,A}=A+imm
- 0101 ADD B,imm : {c,B}=B+imm
- 0011 MOV A,imm
- 0111 MOV B,imm
- 0001 MOV A,B
- 0100 MOV B,A
- 0010 IN A : A=sw_in
- 0110 IN B : B=sw_in
- 1001 OUT B : led=B
- 1011 OUT imm : led=imm
- 1111 JMP imm : pc=imm
- 1110 JNC imm : pc = carry ? pc+1 : imm, using carry from the previous instruction
- Any other opcode: NOP.

Arithmetic and flags:
- ADD is modulo 2**W; carry = bit W of the sum.
- Every executed non-ADD instruction clears carry.
- pc increments modulo 2**W: pc = 2**W-1 with a non-jump wraps to 0.

Reset mid-operation: returns to LOAD with pc=0 and the program intact; asserting run restarts it from address 0.

Optional Feature:
TD4X_HALT_EN
- Defined: opcode 1000 = HALT. The FSM enters state HALT; pc stays at the HALT address; tick, run and prog_we are ignored. Output halted (1 bit) = 1; running = 0. Only RST exits HALT.
- Undefined: 1000 is a NOP, there is no HALT state, and there is no halted port.

Decomposition:
- Shared package td4x_pkg: opcode localparams (OP_ADD_A … OP_JNC, OP_HALT), FSM state encoding (ST_LOAD, ST_RUN, ST_HALT), OPC_W.
- Sub-module td4x_prog_mem: 2**W x (OPC_W+W) array, synchronous write, asynchronous read, no reset.
- Decode, datapath and FSM stay in td4x_core.

Test Plan:
1. W=4. Load mem0=1011_0111, mem1=0000_0001, mem2=1110_0001, mem3=1111_0011; run=1; tick every cycle.
   -> led=7 after tick 1; A counts 1..15,0; pc==3 and A==0 after tick 33; pc holds 3 thereafter.
2. Same program. Hold tick=0 for 10 cycles mid-count -> pc, A, led and carry unchanged. Drive prog_we=1 to mem1 during RUN -> mem1 unchanged (confirm by program behaviour).
3. sw_in=4'hA. Program IN A (0010_0000), MOV B,A (0100_0000), OUT B (1001_0000) -> led=4'hA after tick 3. run=0 then run=1 resumes with pc=3.
4. Assert RST for one cycle after tick 20 of test 1 -> next cycle pc=0, led=0, carry=0, running=0. Re-assert run -> led=7 after first tick (ROM preserved).
5. W=8. MOV A,0x01 then ADD A,0xFF -> A=0x00, carry=1. Next JNC 0x40 -> falls through to pc=3 and carry clears.
6. TD4X_HALT_EN defined. Program OUT 5, HALT -> led=5, halted=1, pc=1 stays fixed for 20 ticks with run toggling; RST clears halted and returns to LOAD.
